uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 172 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Brief    : 4-entry buffered UART transmitter, 8 data bits + even parity + stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       full,
  output logic [2:0] count,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int unsigned c_fifo_depth = 4;
  localparam logic [7:0]  c_last_clk   = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_fifo [c_fifo_depth];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [7:0] r_shift;
  logic [7:0] r_clk_cnt;
  logic [7:0] w_clk_cnt_next;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_next;
  logic       r_tx;
  logic       w_tx_next;
  logic       r_overflow;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;

  // Full comes from the registered count, so a same-edge pop never frees a slot.
  assign w_full    = (r_count == 3'(c_fifo_depth));
  assign w_push    = send && !w_full;
  assign w_bit_end = (r_clk_cnt == c_last_clk);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_overflow <= send && w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_shift  <= r_fifo[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // tx is registered from the next-state value so the start bit appears on the pop edge.
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_clk_cnt_next = r_clk_cnt + 8'd1;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_next = '0;
        w_tx_next      = 1'b1;
        if (r_count != 3'd0) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_PARITY;
            w_tx_next    = ^r_shift;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[r_bit_idx + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_state_next   = S_STOP;
          w_tx_next      = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_count != 3'd0) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_clk_cnt_next = '0;
        w_tx_next      = 1'b1;
      end
    endcase
  end

  assign full     = w_full;
  assign count    = r_count;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;
  assign tx       = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Brief    : Self-checking bench: two DUTs (1 and 3 clocks/bit) against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       send;
  logic       full0, busy0, ov0, tx0;
  logic       full1, busy1, ov1, tx1;
  logic [2:0] count0, count1;

  int checks = 0;
  int errors = 0;

  uart_transmitter #(.CLKS_PER_BIT(1)) u_dut0 (
    .clk(clk), .reset(reset), .data(data), .send(send),
    .full(full0), .count(count0), .busy(busy0), .overflow(ov0), .tx(tx0)
  );

  uart_transmitter #(.CLKS_PER_BIT(3)) u_dut1 (
    .clk(clk), .reset(reset), .data(data), .send(send),
    .full(full1), .count(count1), .busy(busy1), .overflow(ov1), .tx(tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a list of accepted bytes plus the byte on the line and its cycle offset.
  logic [7:0] mq   [2][8];
  int         mn   [2];
  bit         mbusy[2];
  int         mpos [2];
  logic [7:0] mcur [2];
  bit         mov  [2];

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int i, input int cpb);
    if (!mbusy[i]) return 1'b1;
    return frame_bit(mcur[i], mpos[i] / cpb);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mbusy[i] = 0; mpos[i] = 0; mcur[i] = '0; mov[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int cpb);
    bit accept;
    accept = send && (mn[i] < 4);
    mov[i] = send && (mn[i] == 4);
    if (mbusy[i]) begin
      mpos[i]++;
      if (mpos[i] == 11 * cpb) mbusy[i] = 0;
    end
    if (!mbusy[i] && mn[i] > 0) begin
      mcur[i] = mq[i][0];
      for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
      mn[i]--;
      mbusy[i] = 1;
      mpos[i] = 0;
    end
    if (accept) begin
      mq[i][mn[i]] = data;
      mn[i]++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else begin
        model_step(0, 1);
        model_step(1, 3);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("tx0",    tx0,    exp_tx(0, 1));
      chk("busy0",  busy0,  mbusy[0]);
      chk("count0", count0, mn[0]);
      chk("full0",  full0,  mn[0] == 4);
      chk("ovf0",   ov0,    mov[0]);
      chk("tx1",    tx1,    exp_tx(1, 3));
      chk("busy1",  busy1,  mbusy[1]);
      chk("count1", count1, mn[1]);
      chk("full1",  full1,  mn[1] == 4);
      chk("ovf1",   ov1,    mov[1]);
    end
  end

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk); #1; send = 1'b1; data = d;
    @(negedge clk); #1; send = 1'b0;
  endtask

  task automatic collect0(output logic [10:0] v, output int nb);
    nb = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      v[i] = tx0;
      if (busy0) nb++;
    end
  endtask

  task automatic burst5(input bit extra, input logic [7:0] xd);
    logic [7:0] b [5];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44; b[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1; send = 1'b1; data = b[i];
    end
    @(negedge clk); #1; send = extra; data = xd;
  endtask

  initial begin
    logic [10:0] v;
    int nb;
    reset = 1'b1; send = 1'b0; data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx0", tx0, 1); chk("rst_busy0", busy0, 0); chk("rst_count0", count0, 0);
    chk("rst_full0", full0, 0); chk("rst_ovf0", ov0, 0); chk("rst_tx1", tx1, 1);

    // First edge after reset release carries a valid push.
    reset = 1'b0; send = 1'b1; data = 8'hA5;
    @(negedge clk); #1; send = 1'b0;
    collect0(v, nb);
    chk("frame_a5", v, 11'b10101001010);
    chk("busy_a5", nb, 11);
    @(negedge clk);
    chk("idle_busy", busy0, 0); chk("idle_tx", tx0, 1);
    repeat (40) @(negedge clk);

    send_byte(8'h07);
    collect0(v, nb);
    chk("frame_07", v, 11'b11000001110);
    repeat (40) @(negedge clk);
    send_byte(8'h00);
    collect0(v, nb);
    chk("frame_00", v, 11'b10000000000);
    repeat (40) @(negedge clk);

    send_byte(8'h3C);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy1) nb++; else break;
    end
    chk("frame_len_c3", nb, 33);
    repeat (10) @(negedge clk);

    // Five back-to-back pushes: one pops immediately, four stay buffered.
    burst5(1'b0, 8'h00);
    chk("burst_full0", full0, 1); chk("burst_count0", count0, 4);
    chk("burst_full1", full1, 1); chk("burst_count1", count1, 4);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy0) nb++; else break;
    end
    chk("burst_contig", nb, 51);
    repeat (200) @(negedge clk);

    burst5(1'b1, 8'h99);
    @(negedge clk);
    chk("ovf_pulse0", ov0, 1); chk("ovf_count0", count0, 4); chk("ovf_pulse1", ov1, 1);
    #1; send = 1'b0;
    @(negedge clk);
    chk("ovf_clear0", ov0, 0);
    repeat (250) @(negedge clk);

    // Async reset in the middle of a data bit with two bytes waiting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1; send = 1'b1; data = 8'hC0 + 8'(i);
    end
    @(negedge clk); #1; send = 1'b0;
    repeat (4) @(negedge clk);
    #1; reset = 1'b1; #1;
    chk("arst_tx0", tx0, 1); chk("arst_count0", count0, 0); chk("arst_busy0", busy0, 0);
    chk("arst_full0", full0, 0); chk("arst_tx1", tx1, 1); chk("arst_count1", count1, 0);
    @(negedge clk); #1; reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_busy0", busy0, 0); chk("post_rst_tx0", tx0, 1);

    for (int c = 0; c < 900; c++) begin
      @(negedge clk); #1;
      send = ($urandom_range(0, 2) == 0);
      data = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1; reset = 1'b1; #1; reset = 1'b0;
      end
    end
    @(negedge clk); #1; send = 1'b0;
    repeat (200) @(negedge clk);
    chk("final_busy0", busy0, 0); chk("final_busy1", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
